// File: rtl/fmt_grant_ctrl.sv
// Grant controller for the formatter output port: reserves sink credits per packet,
// forwards words to the sink one cycle later and polices packet framing and stalls.
module fmt_grant_ctrl #(
  parameter int CREDIT_MAX = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        fmt_req_i,
  input  logic [5:0]  fmt_length_i,
  input  logic [1:0]  fmt_chid_i,
  input  logic [31:0] fmt_data_i,
  input  logic        fmt_start_i,
  input  logic        fmt_end_i,
  output logic        fmt_grant_o,
  input  logic        crd_ret_i,
  output logic        sink_valid_o,
  output logic [31:0] sink_data_o,
  output logic [1:0]  sink_chid_o,
  output logic        sink_sop_o,
  output logic        sink_eop_o,
  output logic [6:0]  credit_o,
  output logic        busy_o,
  output logic        err_len_o,
  output logic        err_tmo_o,
  output logic [15:0] pkt_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT      = 2'd1,
    WAIT_SOP = 2'd2,
    XFER     = 2'd3
  } state_t;

  localparam logic [6:0] CREDIT_FULL = 7'(CREDIT_MAX);
  localparam logic [7:0] WDOG_LAST   = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  len;
  logic [7:0]  wc;
  logic [7:0]  wdog;
  logic [6:0]  credit;
  logic [15:0] pkt_cnt;

  logic        grant_ok;
  logic        accept;
  logic        sop;
  logic        fwd;
  logic        eop;
  logic        done;
  logic        tmo;
  logic        len_err;
  logic [7:0]  idx;
  logic [7:0]  total;
  logic [7:0]  len_ext;
  logic [6:0]  deduct;
  logic [6:0]  refund;
  logic [6:0]  fwd_cnt;
  logic [8:0]  credit_sum;
  logic [6:0]  credit_nxt;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sop       = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    len_err   = 1'b0;
    deduct    = 7'd0;
    refund    = 7'd0;
    idx       = wc;
    len_ext   = {2'b00, len};
    grant_ok  = en_i && fmt_req_i && (fmt_length_i != 6'd0) &&
                ({1'b0, fmt_length_i} <= credit);
    fwd_cnt   = (wc >= len_ext) ? {1'b0, len} : wc[6:0];

    case (state)
      IDLE: begin
        if (grant_ok) begin
          state_nxt = GNT;
          deduct    = {1'b0, fmt_length_i};
        end
      end
      GNT: begin
        state_nxt = WAIT_SOP;
      end
      WAIT_SOP: begin
        if (fmt_start_i) begin
          accept = 1'b1;
          idx    = 8'd0;
          sop    = 1'b1;
        end
      end
      XFER: begin
        accept = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    total = idx + 8'd1;

    // A packet ending on the watchdog's last cycle still completes normally;
    // otherwise the watchdog abort discards the word presented that cycle.
    if (accept && fmt_end_i) begin
      done      = 1'b1;
      state_nxt = IDLE;
      len_err   = (total != len_ext);
      if (total < len_ext) begin
        refund = {1'b0, len} - total[6:0];
      end
    end else if ((state == WAIT_SOP || state == XFER) && wdog == WDOG_LAST) begin
      tmo       = 1'b1;
      accept    = 1'b0;
      sop       = 1'b0;
      state_nxt = IDLE;
      refund    = {1'b0, len} - fwd_cnt;
    end else if (accept && state == WAIT_SOP) begin
      state_nxt = XFER;
    end

    fwd = accept && (idx < len_ext);
    eop = fwd && (fmt_end_i || (idx == len_ext - 8'd1));

    credit_sum = {2'b00, credit} + {2'b00, refund} + {8'd0, crd_ret_i} - {2'b00, deduct};
    credit_nxt = (credit_sum > {2'b00, CREDIT_FULL}) ? CREDIT_FULL : credit_sum[6:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      credit <= CREDIT_FULL;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
    end
  end

  // Packet bookkeeping: the watchdog starts from zero in the grant cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len     <= 6'd0;
      wc      <= 8'd0;
      wdog    <= 8'd0;
      pkt_cnt <= 16'd0;
    end else begin
      if (state == IDLE && grant_ok) begin
        len  <= fmt_length_i;
        wc   <= 8'd0;
        wdog <= 8'd0;
      end else if (state != IDLE) begin
        wdog <= wdog + 8'd1;
      end
      if (accept) begin
        wc <= total;
      end
      if (done) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sink_valid_o <= 1'b0;
      sink_data_o  <= 32'd0;
      sink_chid_o  <= 2'd0;
      sink_sop_o   <= 1'b0;
      sink_eop_o   <= 1'b0;
      err_len_o    <= 1'b0;
      err_tmo_o    <= 1'b0;
    end else begin
      sink_valid_o <= fwd;
      sink_sop_o   <= sop && fwd;
      sink_eop_o   <= eop;
      if (fwd) begin
        sink_data_o <= fmt_data_i;
        sink_chid_o <= fmt_chid_i;
      end
      err_len_o <= len_err;
      err_tmo_o <= tmo;
    end
  end

  assign fmt_grant_o = (state == GNT);
  assign busy_o      = (state != IDLE);
  assign credit_o    = credit;
  assign pkt_cnt_o   = pkt_cnt;

endmodule

// File: tb/tb_fmt_grant_ctrl.sv
// Self-checking bench for fmt_grant_ctrl: sink words are checked against a queue of
// expected words filled as the formatter side is driven.
module tb_fmt_grant_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        req = 1'b0;
  logic [5:0]  length = 6'd0;
  logic [1:0]  chid = 2'd0;
  logic [31:0] data = 32'd0;
  logic        start_w = 1'b0;
  logic        end_w = 1'b0;
  logic        crd_ret = 1'b0;
  logic        grant;
  logic        sink_valid;
  logic [31:0] sink_data;
  logic [1:0]  sink_chid;
  logic        sink_sop;
  logic        sink_eop;
  logic [6:0]  credit;
  logic        busy;
  logic        err_len;
  logic        err_tmo;
  logic [15:0] pkt_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int err_len_seen = 0;
  int err_tmo_seen = 0;
  int grant_seen = 0;
  logic [35:0] exp_q[$];

  fmt_grant_ctrl #(.CREDIT_MAX(64), .TIMEOUT(10)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .fmt_req_i(req), .fmt_length_i(length),
    .fmt_chid_i(chid), .fmt_data_i(data), .fmt_start_i(start_w), .fmt_end_i(end_w),
    .fmt_grant_o(grant), .crd_ret_i(crd_ret), .sink_valid_o(sink_valid),
    .sink_data_o(sink_data), .sink_chid_o(sink_chid), .sink_sop_o(sink_sop),
    .sink_eop_o(sink_eop), .credit_o(credit), .busy_o(busy), .err_len_o(err_len),
    .err_tmo_o(err_tmo), .pkt_cnt_o(pkt_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: every forwarded sink word must match the oldest expected word.
  always @(negedge clk) begin
    if (sink_valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL sink_unexpected: got %h, expected no word",
                 {sink_data, sink_chid, sink_sop, sink_eop});
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if ({sink_data, sink_chid, sink_sop, sink_eop} !== e) begin
          tests_failed++;
          $display("[TB] FAIL sink_word: got %h, expected %h",
                   {sink_data, sink_chid, sink_sop, sink_eop}, e);
        end
      end
    end
    if (err_len) err_len_seen++;
    if (err_tmo) err_tmo_seen++;
    if (grant) grant_seen++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request_grant(input logic [5:0] l, output int waited);
    req = 1'b1;
    length = l;
    waited = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (grant) begin
        waited = i;
        break;
      end
    end
    req = 1'b0;
    length = 6'd0;
    tests_run++;
    if (waited != 0) begin
      tests_failed++;
      $display("[TB] FAIL grant_latency len=%0d: got %0d cycles, expected 0", l, waited);
    end
  endtask

  // Called in the grant cycle; sends n words with end on the last one.
  task automatic drive_words(input int n, input int l);
    step();
    for (int i = 0; i < n; i++) begin
      data = $urandom;
      chid = 2'(i);
      start_w = (i == 0);
      end_w = (i == n - 1);
      if (i < l) exp_q.push_back({data, chid, (i == 0), ((i == n - 1) || (i == l - 1))});
      step();
    end
    start_w = 1'b0;
    end_w = 1'b0;
    data = 32'd0;
  endtask

  task automatic return_credits(input int n);
    crd_ret = 1'b1;
    for (int i = 0; i < n; i++) step();
    crd_ret = 1'b0;
  endtask

  task automatic test_reset();
    int g0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests_run++;
    if ({grant, sink_valid, sink_data, sink_chid, sink_sop, sink_eop, busy, err_len, err_tmo, pkt_cnt} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got nonzero outputs, expected all zero");
    end
    tests_run++;
    if (credit !== 7'd64) begin
      tests_failed++;
      $display("[TB] FAIL reset_credit: got %0d, expected 64", credit);
    end
    g0 = grant_seen;
    en = 1'b0; req = 1'b1; length = 6'd4;
    for (int i = 0; i < 3; i++) step();
    en = 1'b1; length = 6'd0;
    for (int i = 0; i < 3; i++) step();
    req = 1'b0;
    tests_run++;
    if (grant_seen != g0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL no_grant_disabled_or_zero: got %0d grants, expected 0", grant_seen - g0);
    end
  endtask

  task automatic test_basic();
    int w;
    int g0;
    g0 = grant_seen;
    request_grant(6'd8, w);
    tests_run++;
    if (credit !== 7'd56) begin
      tests_failed++;
      $display("[TB] FAIL basic_credit_deduct: got %0d, expected 56", credit);
    end
    drive_words(8, 8);
    tests_run++;
    if (pkt_cnt !== 16'd1 || busy !== 1'b0 || err_len !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_done: got pkt_cnt=%0d busy=%b err_len=%b, expected 1 0 0", pkt_cnt, busy, err_len);
    end
    tests_run++;
    if (grant_seen - g0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL basic_grant_pulses: got %0d, expected 1", grant_seen - g0);
    end
    return_credits(8);
    tests_run++;
    if (credit !== 7'd64) begin
      tests_failed++;
      $display("[TB] FAIL basic_credit_return: got %0d, expected 64", credit);
    end
  endtask

  task automatic test_credit_stall();
    int w;
    for (int k = 0; k < 7; k++) begin
      request_grant(6'd8, w);
      drive_words(8, 8);
    end
    request_grant(6'd3, w);
    drive_words(3, 3);
    tests_run++;
    if (credit !== 7'd5) begin
      tests_failed++;
      $display("[TB] FAIL stall_credit_start: got %0d, expected 5", credit);
    end
    req = 1'b1; length = 6'd8;
    for (int i = 0; i < 3; i++) step();
    crd_ret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (grant !== 1'b0 || credit !== 7'(6 + i)) begin
        tests_failed++;
        $display("[TB] FAIL stall_no_grant: got grant=%b credit=%0d, expected 0 %0d", grant, credit, 6 + i);
      end
    end
    crd_ret = 1'b0;
    step();
    req = 1'b0; length = 6'd0;
    tests_run++;
    if (grant !== 1'b1 || credit !== 7'd0) begin
      tests_failed++;
      $display("[TB] FAIL stall_grant: got grant=%b credit=%0d, expected 1 0", grant, credit);
    end
    drive_words(8, 8);
    return_credits(70);
    tests_run++;
    if (credit !== 7'd64) begin
      tests_failed++;
      $display("[TB] FAIL stall_credit_restore: got %0d, expected 64", credit);
    end
  endtask

  task automatic test_overrun();
    int w;
    int p0;
    p0 = pkt_cnt;
    request_grant(6'd4, w);
    drive_words(6, 4);
    tests_run++;
    if (err_len !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL overrun_err_len: got %b, expected 1", err_len);
    end
    step();
    tests_run++;
    if (err_len !== 1'b0 || credit !== 7'd60 || pkt_cnt !== 16'(p0 + 1)) begin
      tests_failed++;
      $display("[TB] FAIL overrun_after: got err=%b credit=%0d pkt=%0d, expected 0 60 %0d", err_len, credit, pkt_cnt, p0 + 1);
    end
    return_credits(4);
  endtask

  task automatic test_underrun();
    int w;
    request_grant(6'd6, w);
    drive_words(3, 6);
    tests_run++;
    if (err_len !== 1'b1 || credit !== 7'd61) begin
      tests_failed++;
      $display("[TB] FAIL underrun: got err=%b credit=%0d, expected 1 61", err_len, credit);
    end
    return_credits(3);
  endtask

  task automatic test_timeout();
    int w;
    int cnt;
    int p0;
    p0 = pkt_cnt;
    request_grant(6'd5, w);
    tests_run++;
    if (credit !== 7'd59) begin
      tests_failed++;
      $display("[TB] FAIL tmo_reserve: got %0d, expected 59", credit);
    end
    cnt = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (err_tmo) begin
        cnt = i;
        break;
      end
    end
    tests_run++;
    if (cnt != 10) begin
      tests_failed++;
      $display("[TB] FAIL tmo_latency: got %0d cycles, expected 10", cnt);
    end
    tests_run++;
    if (busy !== 1'b0 || credit !== 7'd64 || pkt_cnt !== 16'(p0)) begin
      tests_failed++;
      $display("[TB] FAIL tmo_state: got busy=%b credit=%0d pkt=%0d, expected 0 64 %0d", busy, credit, pkt_cnt, p0);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int p0;
    p0 = pkt_cnt;
    request_grant(6'd2, w);
    req = 1'b1; length = 6'd2;
    drive_words(2, 2);
    tests_run++;
    if (grant !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_idle: got grant=%b busy=%b, expected 0 0", grant, busy);
    end
    step();
    req = 1'b0; length = 6'd0;
    tests_run++;
    if (grant !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_grant: got %b, expected 1", grant);
    end
    drive_words(2, 2);
    tests_run++;
    if (pkt_cnt !== 16'(p0 + 2) || credit !== 7'd60) begin
      tests_failed++;
      $display("[TB] FAIL b2b_done: got pkt=%0d credit=%0d, expected %0d 60", pkt_cnt, credit, p0 + 2);
    end
    return_credits(4);
  endtask

  task automatic test_reset_mid();
    int w;
    request_grant(6'd8, w);
    step();
    for (int i = 0; i < 4; i++) begin
      data = $urandom;
      chid = 2'(i);
      start_w = (i == 0);
      if (i < 3) exp_q.push_back({data, chid, (i == 0), 1'b0});
      if (i == 3) rst = 1'b1;
      step();
    end
    rst = 1'b0; start_w = 1'b0; data = 32'd0; chid = 2'd0;
    tests_run++;
    if ({grant, sink_valid, sink_data, sink_chid, sink_sop, sink_eop, busy, err_len, err_tmo, pkt_cnt} !== '0
        || credit !== 7'd64) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got busy=%b valid=%b credit=%0d pkt=%0d, expected 0 0 64 0", busy, sink_valid, credit, pkt_cnt);
    end
    return_credits(5);
    tests_run++;
    if (credit !== 7'd64) begin
      tests_failed++;
      $display("[TB] FAIL credit_saturate: got %0d, expected 64", credit);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_stall();
    test_overrun();
    test_underrun();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    step();
    step();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL sink_missing: got %0d words outstanding, expected 0", exp_q.size());
    end
    tests_run++;
    if (err_len_seen != 2 || err_tmo_seen != 1) begin
      tests_failed++;
      $display("[TB] FAIL err_pulses: got len=%0d tmo=%0d, expected 2 1", err_len_seen, err_tmo_seen);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fmt_grant_ctrl.md
# fmt_grant_ctrl

Downstream grant controller for the formatter output port. It decides when the formatter may send a packet by issuing `fmt_grant`, reserving sink-buffer credits for the packet length in advance. It forwards the packet words to the sink one cycle later and polices the packet framing (length overrun/underrun, stall timeout). It sits between the formatter's `fmt_*` outputs and the external packet sink. It is the only source of `fmt_grant` in the system.

## Interface
- `CREDIT_MAX`, default 64: sink buffer depth in 32-bit words, range 1..127; reset value of the credit counter.
- `TIMEOUT`, default 255: maximum cycles from grant to end-of-packet, range 2..255.
- `clk_i` in 1: single clock, all logic on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `en_i` in 1: 1 = new grants allowed; 0 = no new grants, any in-flight packet still completes.
- `fmt_req_i` in 1: formatter requests to send a packet.
- `fmt_length_i` in 6: packet length in words; valid while `fmt_req_i`=1.
- `fmt_chid_i` in 2: channel id of the current word.
- `fmt_data_i` in 32: packet word.
- `fmt_start_i` in 1: first word of the packet.
- `fmt_end_i` in 1: last word of the packet.
- `fmt_grant_o` out 1: one-cycle grant pulse.
- `crd_ret_i` in 1: sink has freed one word of buffer; one credit per cycle asserted.
- `sink_valid_o` out 1: forwarded word is valid.
- `sink_data_o` out 32: forwarded word.
- `sink_chid_o` out 2: channel id of the forwarded word.
- `sink_sop_o` out 1: forwarded word is start of packet.
- `sink_eop_o` out 1: forwarded word is end of packet.
- `credit_o` out 7: free, unreserved credits.
- `busy_o` out 1: state is not IDLE.
- `err_len_o` out 1: one-cycle pulse on length mismatch.
- `err_tmo_o` out 1: one-cycle pulse on timeout abort.
- `pkt_cnt_o` out 16: count of completed packets, wraps.

## Operation
- State machine states: IDLE, GNT, WAIT_SOP, XFER.
- IDLE → GNT when all of the following hold: `en_i`=1, `fmt_req_i`=1, `fmt_length_i`≠0, and `credit_o` ≥ `fmt_length_i`.
  - Entering GNT latches `len` = `fmt_length_i` and deducts `len` from the credit counter.
  - Length 0 is never granted.
- GNT: `fmt_grant_o`=1 for exactly this one cycle; next state is WAIT_SOP. The watchdog clears to 0.
- WAIT_SOP: waits for `fmt_start_i`=1.
  - The start word is accepted as word 0.
  - If `fmt_end_i` is also 1 on that word, the packet is complete and the next state is IDLE.
  - Otherwise the next state is XFER.
- XFER: every cycle carries one word. The word counter `wc` increments per accepted word. `fmt_start_i` is ignored in this state.
- Framing:
  - The word with `wc` = `len`−1 is forwarded with `sink_eop_o` forced to 1.
  - Words with `wc` ≥ `len` are dropped (`sink_valid_o`=0) until `fmt_end_i` arrives.
  - On `fmt_end_i`, if the total word count ≠ `len`, pulse `err_len_o` one cycle later.
  - If `fmt_end_i` arrives early, refund `len` − words forwarded.
  - The packet completes on `fmt_end_i`: `pkt_cnt_o` +1, next state IDLE.
- Watchdog:
  - Counts cycles in WAIT_SOP and XFER.
  - On reaching `TIMEOUT`, pulse `err_tmo_o`, refund unused reserved credits, and return to IDLE.
  - If the packet was partially forwarded, no extra EOP is generated. `pkt_cnt_o` is not incremented.
- Credit arithmetic:
  - Next credit = credit − grant_len + refund + `crd_ret_i`, all in the same cycle.
  - The result saturates at `CREDIT_MAX`; excess returns are discarded.
  - It never goes below 0, guaranteed by the grant check.
- `fmt_start_i`/`fmt_end_i` seen in IDLE or GNT are ignored and not forwarded.
- `en_i` falling during GNT/WAIT_SOP/XFER has no effect on the in-flight packet.

## Timing
- Reset values of all outputs are 0, except `credit_o` = `CREDIT_MAX`. State after reset is IDLE.
- Reset asserted mid-packet: on the next edge the block is in IDLE with full credits; reserved credits are lost by design. The formatter must be reset together with this block.
- Grant latency: qualifying request sampled in IDLE at edge t → `fmt_grant_o`=1 during cycle t+1. The earliest accepted start is at cycle t+2.
- Forwarding latency: all `sink_*` outputs are registered, one cycle after the accepted `fmt_*` word.
- `credit_o` reflects a grant deduction one cycle after the IDLE→GNT decision edge, and a `crd_ret_i` one cycle after the return.
- Back-to-back packets: end accepted at cycle n → IDLE at n+1 → next grant earliest at n+2.
- `err_len_o` / `err_tmo_o` are registered pulses, coincident with the last forwarded word's `sink_*` cycle or the abort cycle.

## Test plan
- Basic packet:
  - Stimulus: `CREDIT_MAX`=64, `fmt_req_i` with length 8, then start + 8 words + end on word 7.
  - Required response: one grant pulse; 8 sink words with sop on word 0 and eop on word 7; `credit_o` 64→56; with 8 `crd_ret_i` pulses, back to 64; `pkt_cnt_o`=1.
- Credit stall:
  - Stimulus: `credit_o`=5, request length 8.
  - Required response: no grant. After 3 `crd_ret_i` pulses, grant issued the cycle after credit reaches 8.
- Overrun:
  - Stimulus: length 4, formatter sends 6 words.
  - Required response: 4 forwarded words with eop on word 3; words 4–5 dropped; `err_len_o` pulses once; `credit_o` deducted by 4 only.
- Underrun:
  - Stimulus: length 6, end on word 2.
  - Required response: 3 words forwarded with eop on word 2; 3 credits refunded; `err_len_o` pulses.
- Timeout:
  - Stimulus: `TIMEOUT`=10, grant issued, no start.
  - Required response: `err_tmo_o` pulses 10 cycles after grant; credits restored; `busy_o`=0; `pkt_cnt_o` unchanged.
- Reset mid-XFER plus saturation:
  - Stimulus: `rst_i` pulse at word 3.
  - Required response: IDLE, `credit_o`=`CREDIT_MAX`, all outputs 0.
  - Stimulus: then 5 `crd_ret_i` pulses.
  - Required response: `credit_o` stays at `CREDIT_MAX`.
